// File: rtl/run_sequencer_if.sv
// Bundles the preload stream, result stream, data-memory port and core handshake
// seen by run_sequencer; master is the sequencer side, slave the host/memory/core side.
interface run_sequencer_if #(
  parameter int AW = 8
);
  logic          ld_valid;
  logic [7:0]    ld_data;
  logic          ld_ready;
  logic          res_valid;
  logic [7:0]    res_data;
  logic          res_ready;
  logic          mem_own;
  logic [AW-1:0] mem_addr;
  logic          mem_wr_en;
  logic [7:0]    mem_wdata;
  logic [7:0]    mem_rdata;
  logic          core_reset;
  logic          core_req;
  logic          core_done;

  modport master (
    input  ld_valid, ld_data, res_ready, mem_rdata, core_done,
    output ld_ready, res_valid, res_data, mem_own, mem_addr, mem_wr_en, mem_wdata,
           core_reset, core_req
  );

  modport slave (
    output ld_valid, ld_data, res_ready, mem_rdata, core_done,
    input  ld_ready, res_valid, res_data, mem_own, mem_addr, mem_wr_en, mem_wdata,
           core_reset, core_req
  );
endinterface

// File: rtl/run_sequencer.sv
// Host-side run sequencer: preload data memory, reset and launch the core, then stream results.
// Optional run timeout is enabled by defining CORE_TIMEOUT_EN.
module run_sequencer #(
  parameter int AW      = 8,
  parameter int LD_BASE = 0,
  parameter int LD_CNT  = 64,
  parameter int RD_BASE = 64,
  parameter int RD_CNT  = 32,
  parameter int RST_CYC = 2,
  parameter int TMO_CYC = 4095
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  run_sequencer_if.master   bus,
  output logic              busy,
  output logic [1:0]        status,
  output logic [15:0]       run_cycles
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CRST, S_RUN, S_READ} state_e;

  localparam logic [AW-1:0] LD_BASE_A = AW'(LD_BASE);
  localparam logic [AW-1:0] RD_BASE_A = AW'(RD_BASE);
  localparam logic [AW:0]   LD_LAST   = (AW+1)'(LD_CNT - 1);
  localparam logic [AW:0]   RD_LAST   = (AW+1)'(RD_CNT - 1);
  localparam logic [15:0]   RST_LAST  = 16'(RST_CYC - 1);
`ifdef CORE_TIMEOUT_EN
  localparam logic [15:0]   TMO_LIM   = 16'(TMO_CYC);
`else
  logic unused_tmo;
  assign unused_tmo = (TMO_CYC != 0);
`endif

  state_e      state_q, state_d;
  logic [AW:0] idx_q, idx_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] run_cycles_q, run_cycles_d;
  logic [1:0]  status_q, status_d;
  logic        res_valid_q, res_valid_d;
  logic [7:0]  res_data_q, res_data_d;
  logic        req_cycle;

  // run_cycles is cleared on RUN entry and always advances past zero, so zero marks the request cycle
  assign req_cycle = (state_q == S_RUN) && (run_cycles_q == 16'd0);

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    cnt_d          = cnt_q;
    run_cycles_d   = run_cycles_q;
    status_d       = status_q;
    res_valid_d    = res_valid_q;
    res_data_d     = res_data_q;
    bus.ld_ready   = 1'b0;
    bus.mem_own    = 1'b1;
    bus.mem_addr   = LD_BASE_A + idx_q[AW-1:0];
    bus.mem_wr_en  = 1'b0;
    bus.mem_wdata  = bus.ld_data;
    bus.core_reset = 1'b1;
    bus.core_req   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_LOAD;
          status_d = 2'b00;
          idx_d    = '0;
        end
      end

      S_LOAD: begin
        bus.ld_ready = 1'b1;
        if (bus.ld_valid) begin
          bus.mem_wr_en = 1'b1;
          idx_d         = idx_q + 1'b1;
          if (idx_q == LD_LAST) begin
            state_d = S_CRST;
            cnt_d   = '0;
          end
        end
      end

      S_CRST: begin
        bus.mem_own = 1'b0;
        if (cnt_q == RST_LAST) begin
          state_d      = S_RUN;
          run_cycles_d = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      // A done level left over from a previous run is not trusted in the request cycle
      S_RUN: begin
        bus.mem_own    = 1'b0;
        bus.core_reset = 1'b0;
        bus.core_req   = req_cycle;
        if (!req_cycle && bus.core_done) begin
          state_d     = S_READ;
          idx_d       = '0;
          res_valid_d = 1'b0;
        end
`ifdef CORE_TIMEOUT_EN
        else if (run_cycles_q == TMO_LIM) begin
          state_d     = S_READ;
          status_d    = 2'b01;
          idx_d       = '0;
          res_valid_d = 1'b0;
        end
`endif
        else if (run_cycles_q != 16'hFFFF) begin
          run_cycles_d = run_cycles_q + 16'd1;
        end
      end

      // Alternates capture and hand-off, giving one result byte every two cycles
      S_READ: begin
        bus.mem_addr = RD_BASE_A + idx_q[AW-1:0];
        if (!res_valid_q) begin
          res_data_d  = bus.mem_rdata;
          res_valid_d = 1'b1;
        end else if (bus.res_ready) begin
          res_valid_d = 1'b0;
          idx_d       = idx_q + 1'b1;
          if (idx_q == RD_LAST) begin
            state_d = S_IDLE;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      cnt_q        <= '0;
      run_cycles_q <= '0;
      status_q     <= 2'b00;
      res_valid_q  <= 1'b0;
      res_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      run_cycles_q <= run_cycles_d;
      status_q     <= status_d;
      res_valid_q  <= res_valid_d;
      res_data_q   <= res_data_d;
    end
  end

  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign busy          = (state_q != S_IDLE);
  assign status        = status_q;
  assign run_cycles    = run_cycles_q;

endmodule

// File: tb/tb_run_sequencer.sv
// Randomized bench for run_sequencer against a memory-image reference model.
// Rebuild with CORE_TIMEOUT_EN defined to exercise the run timeout.
module tb_run_sequencer;
  localparam int AW      = 8;
  localparam int LD_BASE = 0;
  localparam int LD_CNT  = 4;
  localparam int RD_BASE = 254;
  localparam int RD_CNT  = 4;
  localparam int RST_CYC = 2;
  localparam int TMO_CYC = 20;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        busy;
  logic [1:0]  status;
  logic [15:0] run_cycles;

  run_sequencer_if #(.AW(AW)) bus ();

  run_sequencer #(
    .AW(AW), .LD_BASE(LD_BASE), .LD_CNT(LD_CNT), .RD_BASE(RD_BASE),
    .RD_CNT(RD_CNT), .RST_CYC(RST_CYC), .TMO_CYC(TMO_CYC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .bus(bus.master),
    .busy(busy),
    .status(status),
    .run_cycles(run_cycles)
  );

  always #5 clk = ~clk;

  logic [7:0]  mem [256];
  logic [7:0]  ref_mem [256];
  logic [7:0]  ld_bytes [LD_CNT];
  logic [15:0] wr_log [$];
  logic        init_we = 1'b0;
  logic [7:0]  init_addr = '0;
  logic [7:0]  init_data = '0;
  logic        core_we = 1'b0;
  logic [7:0]  core_addr = '0;
  logic [7:0]  core_wdata = '0;
  int          n_checks = 0;
  int          n_pass = 0;
  int          last_run = 0;

  // Data memory shared by the sequencer and a core model that writes one result at done
  assign bus.mem_rdata = mem[bus.mem_addr];

  always @(posedge clk) begin
    if (init_we) begin
      mem[init_addr] <= init_data;
    end else if (bus.mem_own && bus.mem_wr_en) begin
      mem[bus.mem_addr] <= bus.mem_wdata;
      wr_log.push_back({bus.mem_addr, bus.mem_wdata});
    end else if (!bus.mem_own && core_we) begin
      mem[core_addr] <= core_wdata;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic load_bytes(input int gap_mode);
    int base;
    base = wr_log.size();
    for (int i = 0; i < LD_CNT; i++) begin
      int g;
      g = (gap_mode < 0) ? int'($urandom_range(0, 2)) : gap_mode;
      bus.ld_valid = 1'b0;
      repeat (g) @(negedge clk);
      bus.ld_valid = 1'b1;
      bus.ld_data  = ld_bytes[i];
      #1;
      checkOutput("ld_wr_en", bus.mem_wr_en, 1);
      checkOutput("ld_addr", bus.mem_addr, (LD_BASE + i) % 256);
      ref_mem[(LD_BASE + i) % 256] = ld_bytes[i];
      @(negedge clk);
    end
    bus.ld_valid = 1'b0;
    checkOutput("ld_wr_count", wr_log.size() - base, LD_CNT);
    for (int i = 0; i < LD_CNT; i++) begin
      if (base + i < wr_log.size())
        checkOutput("ld_wr_log", wr_log[base + i], {8'((LD_BASE + i) % 256), ld_bytes[i]});
    end
  endtask

  // One full run: start, preload, core reset, core run with a done model, readback
  task automatic applyStimulus(input int gap_mode, input int done_at, input bit stale);
    int cyc, bad, k, n, req_extra, exp_run, base;
    bit tmo, core_wrote;
    logic [7:0] cw;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("load_busy", busy, 1);
    checkOutput("load_ready", bus.ld_ready, 1);
    checkOutput("status_clr", status, 0);
    load_bytes(gap_mode);
    base = wr_log.size();
    if (stale) bus.core_done = 1'b1;

    cyc = 0;
    bad = 0;
    while (!bus.core_req && cyc < 20) begin
      if (!bus.core_reset || bus.mem_own || bus.ld_ready) bad++;
      cyc++;
      @(negedge clk);
    end
    checkOutput("crst_len", cyc, RST_CYC);
    checkOutput("crst_hold", bad, 0);
    checkOutput("req_core_rst", bus.core_reset, 0);

    k = 0;
    req_extra = 0;
    core_wrote = 1'b0;
    cw = '0;
    while (!bus.mem_own && k < 80) begin
      if (k > 0 && bus.core_req) req_extra++;
      if (k == done_at) begin
        bus.core_done = 1'b1;
        cw = 8'($urandom);
        core_we = 1'b1;
        core_addr = 8'(RD_BASE % 256);
        core_wdata = cw;
        core_wrote = 1'b1;
      end else begin
        core_we = 1'b0;
      end
      start = 1'($urandom_range(0, 1));
      bus.ld_valid = 1'($urandom_range(0, 1));
      bus.ld_data = 8'($urandom);
      @(negedge clk);
      k++;
    end
    core_we = 1'b0;
    bus.core_done = 1'b0;
    start = 1'b0;
    bus.ld_valid = 1'b0;
    if (core_wrote) ref_mem[RD_BASE % 256] = cw;

`ifdef CORE_TIMEOUT_EN
    tmo = (done_at > TMO_CYC);
`else
    tmo = 1'b0;
`endif
    exp_run = tmo ? TMO_CYC : done_at;
    last_run = exp_run;
    checkOutput("run_exit", k, exp_run + 1);
    checkOutput("run_cycles", run_cycles, exp_run);
    checkOutput("run_status", status, tmo ? 1 : 0);
    checkOutput("single_req", req_extra, 0);
    checkOutput("read_core_rst", bus.core_reset, 1);
    checkOutput("read_first_nv", bus.res_valid, 0);

    n = 0;
    cyc = 0;
    while (n < RD_CNT && cyc < 200) begin
      if (!bus.res_valid) checkOutput("rd_addr", bus.mem_addr, (RD_BASE + n) % 256);
      bus.res_ready = 1'($urandom_range(0, 1));
      #1;
      if (bus.res_valid && bus.res_ready) begin
        checkOutput("rd_data", bus.res_data, ref_mem[(RD_BASE + n) % 256]);
        n++;
      end
      @(negedge clk);
      cyc++;
    end
    bus.res_ready = 1'b0;
    checkOutput("rd_count", n, RD_CNT);
    checkOutput("idle_busy", busy, 0);
    checkOutput("idle_res_valid", bus.res_valid, 0);
    checkOutput("idle_own", bus.mem_own, 1);
    checkOutput("run_hold", run_cycles, last_run);
    checkOutput("no_stray_wr", wr_log.size(), base);
  endtask

  initial begin
    int d;
    bus.ld_valid = 1'b0;
    bus.ld_data = '0;
    bus.res_ready = 1'b0;
    bus.core_done = 1'b0;
    reset = 1'b0;
    start = 1'b1;
    @(negedge clk);
    for (int a = 0; a < 256; a++) begin
      init_we = 1'b1;
      init_addr = 8'(a);
      init_data = 8'($urandom);
      ref_mem[a] = init_data;
      @(negedge clk);
    end
    init_we = 1'b0;
    bus.ld_valid = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_core_rst", bus.core_reset, 1);
    checkOutput("rst_own", bus.mem_own, 1);
    checkOutput("rst_ld_ready", bus.ld_ready, 0);
    checkOutput("rst_wr_en", bus.mem_wr_en, 0);
    checkOutput("rst_req", bus.core_req, 0);
    checkOutput("rst_res_valid", bus.res_valid, 0);
    checkOutput("rst_status", status, 0);
    checkOutput("rst_run_cycles", run_cycles, 0);
    bus.ld_valid = 1'b0;
    start = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    checkOutput("idle_no_start", busy, 0);

    ld_bytes[0] = 8'h11;
    ld_bytes[1] = 8'h22;
    ld_bytes[2] = 8'h33;
    ld_bytes[3] = 8'h44;
    $display("[TB] run 1: fixed preload, done after 10 cycles");
    applyStimulus(2, 10, 1'b0);

    for (int i = 0; i < LD_CNT; i++) ld_bytes[i] = 8'($urandom);
    $display("[TB] run 2: stale done");
    applyStimulus(-1, 1, 1'b0 | 1'b1);

    for (int i = 0; i < LD_CNT; i++) ld_bytes[i] = 8'($urandom);
    $display("[TB] run 3: late done, timeout if enabled");
    applyStimulus(-1, 50, 1'b0);

    $display("[TB] reset during preload");
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    bus.ld_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      bus.ld_data = 8'($urandom);
      ref_mem[(LD_BASE + i) % 256] = bus.ld_data;
      @(negedge clk);
    end
    bus.ld_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_ld_ready", bus.ld_ready, 0);
    checkOutput("abort_core_rst", bus.core_reset, 1);
    checkOutput("abort_run_cycles", run_cycles, 0);
    reset = 1'b1;
    @(negedge clk);

    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < LD_CNT; i++) ld_bytes[i] = 8'($urandom);
      d = int'($urandom_range(2, 15));
      $display("[TB] random run, done after %0d cycles", d);
      applyStimulus(-1, d, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
